unfold_serializer: RTL and testbench
====================================

UNFOLD_SERIALIZER -- requirements
Module: unfold_serializer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- WIDTH, 13, sample width in bits (two's complement).
- LANES, 3, unfolding factor (samples per input beat).
- DEPTH, 2, triplet buffer entries.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, single clock, rising edge.
- RST_N, in, 1, asynchronous active-low reset.
- DIN0, in, WIDTH, lane 0 sample (oldest in time).
- DIN1, in, WIDTH, lane 1 sample.
- DIN2, in, WIDTH, lane 2 sample (newest in time).
- VIN, in, 1, input triplet valid.
- RDY, out, 1, buffer can accept a triplet this cycle.
- DOUT, out, WIDTH, serial sample.
- VOUT, out, 1, DOUT valid.
- ERR, out, 1, sticky overflow flag (see Configuration).

REQ-003 The design SHALL use one clock, with reset asynchronous and active-low; this is already decided.

Function
REQ-004 A triplet SHALL be accepted on a rising CLK edge where VIN=1 and RDY=1; it is written to the buffer tail as {DIN0,DIN1,DIN2}.
REQ-005 VIN=1 with RDY=0 SHALL be ignored; no buffer state changes.
REQ-006 RDY SHALL be 1 exactly when the registered entry count is below DEPTH.
- RDY SHALL NOT look ahead to a same-cycle pop.
- When full, RDY=0 even on the cycle lane 2 leaves.
REQ-007 The output FSM SHALL have states IDLE, L0, L1, L2, where Lk means lane k of the head entry is driven on DOUT this cycle.
REQ-008 FSM transitions SHALL be evaluated at each edge:
- IDLE->L0 if count>0 at that edge.
- L0->L1 and L1->L2 unconditionally.
- L2->L0 if count after the pop is >0, else L2->IDLE.
REQ-009 The head entry SHALL be popped on the edge leaving L2.
REQ-010 DOUT and VOUT SHALL be registered.
- VOUT=1 in L0/L1/L2 and 0 in IDLE.
- DOUT holds its last value in IDLE.
REQ-011 Latency: a triplet accepted into an empty buffer at edge t SHALL produce lane 0 after edge t+1, lane 1 after t+2 and lane 2 after t+3.
REQ-012 Sustained throughput SHALL be one sample per cycle, with no bubble between consecutive buffered triplets (L2->L0 directly).
REQ-013 A simultaneous push and pop SHALL leave count unchanged; the pushed entry follows FIFO order.
REQ-014 Samples SHALL pass bit-exact with no arithmetic; sign and MSB are preserved.
REQ-015 Buffer pointers SHALL wrap modulo DEPTH.

Reset
REQ-016 RST_N=0 SHALL immediately, without waiting for CLK, force:
- FSM=IDLE, count=0, pointers=0.
- DOUT=0, VOUT=0, ERR=0.
REQ-017 Reset asserted mid-emission SHALL discard all buffered and partially emitted triplets.
REQ-018 After RST_N deasserts, RDY SHALL be 1 on the first cycle.

Configuration
REQ-019 With macro SER_OVF_DET_EN defined, ERR SHALL be set on any edge where VIN=1 and RDY=0, and SHALL remain 1 until reset.
REQ-020 Without SER_OVF_DET_EN, ERR SHALL be tied to 0 and no detection logic SHALL be synthesized.

Structure
REQ-021 Package ser_pkg SHALL hold:
- constants WIDTH=13, LANES=3, DEPTH=2;
- the FSM state type with encodings IDLE=00, L0=01, L1=10, L2=11;
- the triplet entry type.
REQ-022 Sub-module ser_fifo SHALL implement the DEPTH-entry triplet buffer, providing push, pop, count and head outputs.
REQ-023 unfold_serializer SHALL contain the FSM, the output registers and the ERR logic.

Verification
REQ-024 Reset check: assert RST_N=0 mid-clock -> DOUT=0, VOUT=0, ERR=0 at once, and RDY=1 after release.
REQ-025 Single triplet: one VIN beat with (100,200,300) -> DOUT=100,200,300 on three consecutive cycles starting one cycle after acceptance, VOUT=1 for exactly 3 cycles, then IDLE.
REQ-026 Back-to-back input: VIN=1 every cycle with triplets (1,2,3),(4,5,6),(7,8,9)... ->
- RDY drops after 2 accepts and reasserts periodically;
- DOUT=1,2,3,4,5,6,... continuously with no gap and no loss;
- every accepted triplet is emitted exactly once.
REQ-027 Sign extremes: triplet (-4096, 4095, -1) -> DOUT=0x1000, 0x0FFF, 0x1FFF bit-exact.
REQ-028 Reset during L1 with 2 entries buffered -> VOUT=0 next cycle; a subsequent triplet (10,20,30) emits correctly from lane 0.
REQ-029 Overflow with SER_OVF_DET_EN: VIN=1 while RDY=0 -> ERR=1 on the next cycle and held through idle until reset; the same stimulus without the macro -> ERR stays 0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared constants, FSM state encoding and triplet entry layout for the unfolding serializer.
package ser_pkg;

  localparam int WIDTH = 13;
  localparam int LANES = 3;
  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    L0   = 2'b01,
    L1   = 2'b10,
    L2   = 2'b11
  } state_t;

  // Lane 0 (oldest sample) occupies the most significant slice of an entry.
  typedef struct packed {
    logic [WIDTH-1:0] l0;
    logic [WIDTH-1:0] l1;
    logic [WIDTH-1:0] l2;
  } triplet_t;

endpackage

// File: rtl/ser_fifo.sv
// DEPTH-entry triplet buffer with registered count, head view and a peek at the entry behind the head.
// next_dat bypasses a same-cycle push so the reader can chain entries without a bubble.
module ser_fifo #(
  parameter int ENTRY_W = ser_pkg::LANES * ser_pkg::WIDTH,
  parameter int DEPTH   = ser_pkg::DEPTH,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_dat,
  input  logic               pop,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      count_nxt,
  output logic [ENTRY_W-1:0] head_dat,
  output logic [ENTRY_W-1:0] next_dat
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      rd_ptr_inc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_ptr_inc = ptr_inc(rd_ptr);

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  // With a single entry held, a push lands exactly behind the head.
  assign next_dat = (push && count == CW'(1)) ? push_dat : mem[rd_ptr_inc];

endmodule

// File: rtl/unfold_serializer.sv
// Unfolds triplets of samples into a one-sample-per-cycle registered stream through a small buffer.
// Define SER_OVF_DET_EN to build the sticky ERR flag for triplets offered while the buffer is full.
module unfold_serializer #(
  parameter int WIDTH = ser_pkg::WIDTH,
  parameter int LANES = ser_pkg::LANES,
  parameter int DEPTH = ser_pkg::DEPTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN0,
  input  logic [WIDTH-1:0] DIN1,
  input  logic [WIDTH-1:0] DIN2,
  input  logic             VIN,
  output logic             RDY,
  output logic [WIDTH-1:0] DOUT,
  output logic             VOUT,
  output logic             ERR
);

  import ser_pkg::*;

  localparam int ENTRY_W = LANES * WIDTH;
  localparam int CW      = $clog2(DEPTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   dout_nxt;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_dat;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [ENTRY_W-1:0] head_dat;
  logic [ENTRY_W-1:0] next_dat;

  function automatic logic [WIDTH-1:0] lane_of(input logic [ENTRY_W-1:0] e, input int k);
    return e[(LANES - 1 - k) * WIDTH +: WIDTH];
  endfunction

  assign RDY      = (count < CW'(DEPTH));
  assign push     = VIN && RDY;
  assign pop      = (state == L2);
  assign push_dat = ENTRY_W'({DIN0, DIN1, DIN2});

  ser_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (pop),
    .count     (count),
    .count_nxt (count_nxt),
    .head_dat  (head_dat),
    .next_dat  (next_dat)
  );

  always_comb begin
    state_nxt = state;
    dout_nxt  = DOUT;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = L0;
          dout_nxt  = lane_of(head_dat, 0);
        end
      end
      L0: begin
        state_nxt = L1;
        dout_nxt  = lane_of(head_dat, 1);
      end
      L1: begin
        state_nxt = L2;
        dout_nxt  = lane_of(head_dat, 2);
      end
      L2: begin
        // The head is popped on this edge, so the following entry starts at once.
        if (count_nxt != '0) begin
          state_nxt = L0;
          dout_nxt  = lane_of(next_dat, 0);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      DOUT  <= '0;
      VOUT  <= 1'b0;
    end else begin
      state <= state_nxt;
      DOUT  <= dout_nxt;
      VOUT  <= (state_nxt != IDLE);
    end
  end

`ifdef SER_OVF_DET_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else if (VIN && !RDY) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_unfold_serializer.sv
// Directed bench for unfold_serializer: sample-queue model checked every cycle plus literal expectations.
module tb_unfold_serializer;

  localparam int D = 2;
`ifdef SER_OVF_DET_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [12:0] DIN0 = '0;
  logic [12:0] DIN1 = '0;
  logic [12:0] DIN2 = '0;
  logic        VIN = 1'b0;
  logic        RDY;
  logic [12:0] DOUT;
  logic        VOUT;
  logic        ERR;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: pending entry count, queue of not-yet-shown samples, and what is on the output.
  int          m_cnt = 0;
  logic [12:0] sq[$];
  bit          m_vout = 1'b0;
  int          m_lane = 0;
  logic [12:0] m_dout = '0;
  bit          m_err = 1'b0;

  logic [12:0] out_log[$];
  int          out_cyc[$];

  unfold_serializer dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .DIN0  (DIN0),
    .DIN1  (DIN1),
    .DIN2  (DIN2),
    .VIN   (VIN),
    .RDY   (RDY),
    .DOUT  (DOUT),
    .VOUT  (VOUT),
    .ERR   (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_cnt = 0;
      sq.delete();
      m_vout = 1'b0;
      m_lane = 0;
      m_dout = '0;
      m_err = 1'b0;
    end else begin
      bit acc, pop, idle_start;
      cyc++;
      acc = VIN && (m_cnt < D);
      pop = m_vout && (m_lane == 2);
      idle_start = !m_vout && (sq.size() > 0);
      if (VIN && !(m_cnt < D) && OVF) m_err = 1'b1;
      if (acc) begin
        sq.push_back(DIN0);
        sq.push_back(DIN1);
        sq.push_back(DIN2);
        m_cnt++;
      end
      if (pop) m_cnt--;
      if (m_vout && m_lane < 2) begin
        m_lane++;
        m_dout = sq.pop_front();
      end else if (idle_start || (pop && sq.size() > 0)) begin
        m_vout = 1'b1;
        m_lane = 0;
        m_dout = sq.pop_front();
      end else begin
        m_vout = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("model_rdy", 32'(RDY), 32'(m_cnt < D));
    chk("model_vout", 32'(VOUT), 32'(m_vout));
    chk("model_dout", 32'(DOUT), 32'(m_dout));
    chk("model_err", 32'(ERR), 32'(m_err));
    if (VOUT) begin
      out_log.push_back(DOUT);
      out_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input int a, input int b, input int c);
    DIN0 = 13'(a);
    DIN1 = 13'(b);
    DIN2 = 13'(c);
    VIN = 1'b1;
    step();
    VIN = 1'b0;
  endtask

  initial begin
    int k;
    bit r;
    bit rdy_checked;

    repeat (2) step();
    RST_N = 1'b1;
    step();

    // Reset asserted between edges while a triplet is being emitted.
    push_one(5, 6, 7);
    step();
    #2;
    RST_N = 1'b0;
    #1;
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_vout", 32'(VOUT), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    step();
    RST_N = 1'b1;
    chk("rst_rdy_after", 32'(RDY), 32'd1);
    step();

    // Single triplet.
    push_one(100, 200, 300);
    step();
    chk("single_l0", 32'(DOUT), 32'd100);
    chk("single_v0", 32'(VOUT), 32'd1);
    step();
    chk("single_l1", 32'(DOUT), 32'd200);
    step();
    chk("single_l2", 32'(DOUT), 32'd300);
    chk("single_v2", 32'(VOUT), 32'd1);
    step();
    chk("single_idle_vout", 32'(VOUT), 32'd0);
    chk("single_idle_hold", 32'(DOUT), 32'd300);
    repeat (2) step();

    // Back-to-back triplets offered every cycle.
    out_log.delete();
    out_cyc.delete();
    k = 0;
    rdy_checked = 1'b0;
    for (int n = 0; n < 60 && k < 6; n++) begin
      DIN0 = 13'(3 * k + 1);
      DIN1 = 13'(3 * k + 2);
      DIN2 = 13'(3 * k + 3);
      VIN = 1'b1;
      r = RDY;
      if (k == 2 && !rdy_checked) begin
        chk("b2b_rdy_drop", 32'(RDY), 32'd0);
        rdy_checked = 1'b1;
      end
      step();
      if (r) k++;
    end
    VIN = 1'b0;
    chk("b2b_all_accepted", 32'(k), 32'd6);
    repeat (12) step();
    chk("b2b_count", 32'(out_log.size()), 32'd18);
    if (out_log.size() == 18) begin
      for (int i = 0; i < 18; i++) chk("b2b_sample", 32'(out_log[i]), 32'(i + 1));
      chk("b2b_no_gap", 32'(out_cyc[17] - out_cyc[0]), 32'd17);
    end

    // Sign extremes pass bit-exact.
    push_one(-4096, 4095, -1);
    step();
    chk("sign_l0", 32'(DOUT), 32'h1000);
    step();
    chk("sign_l1", 32'(DOUT), 32'h0FFF);
    step();
    chk("sign_l2", 32'(DOUT), 32'h1FFF);
    repeat (2) step();

    // Reset in L1 with two entries buffered.
    DIN0 = 13'd11; DIN1 = 13'd12; DIN2 = 13'd13; VIN = 1'b1;
    step();
    DIN0 = 13'd14; DIN1 = 13'd15; DIN2 = 13'd16;
    step();
    VIN = 1'b0;
    step();
    chk("l1_lane1", 32'(DOUT), 32'd12);
    chk("l1_full", 32'(RDY), 32'd0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("l1_rst_vout_now", 32'(VOUT), 32'd0);
    step();
    chk("l1_rst_vout_next", 32'(VOUT), 32'd0);
    RST_N = 1'b1;
    chk("l1_rst_rdy", 32'(RDY), 32'd1);
    push_one(10, 20, 30);
    step();
    chk("post_rst_l0", 32'(DOUT), 32'd10);
    step();
    chk("post_rst_l1", 32'(DOUT), 32'd20);
    step();
    chk("post_rst_l2", 32'(DOUT), 32'd30);
    step();
    chk("post_rst_idle", 32'(VOUT), 32'd0);
    step();

    // Overflow: third triplet offered while full.
    out_log.delete();
    DIN0 = 13'd21; DIN1 = 13'd22; DIN2 = 13'd23; VIN = 1'b1;
    step();
    DIN0 = 13'd24; DIN1 = 13'd25; DIN2 = 13'd26;
    step();
    DIN0 = 13'd27; DIN1 = 13'd28; DIN2 = 13'd29;
    chk("ovf_rdy_low", 32'(RDY), 32'd0);
    step();
    VIN = 1'b0;
    chk("ovf_err_set", 32'(ERR), 32'(OVF));
    repeat (10) step();
    chk("ovf_err_hold", 32'(ERR), 32'(OVF));
    chk("ovf_idle", 32'(VOUT), 32'd0);
    chk("ovf_dropped", 32'(out_log.size()), 32'd6);
    if (out_log.size() == 6) chk("ovf_last", 32'(out_log[5]), 32'd26);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ovf_err_clear", 32'(ERR), 32'd0);
    step();
    RST_N = 1'b1;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
